// File: rtl/time_set_ctrl.sv
// Time-of-day controller: h/m/s counters advanced by a 1 Hz tick, with field
// select, up/down editing with press-and-hold auto-repeat, preset load and run/stop.
module time_set_ctrl #(
    parameter int HOURS_MAX = 24,
    parameter int REP_DLY   = 25_000_000,
    parameter int REP_PER   = 5_000_000,
    parameter int PRESET_H  = 12,
    parameter int PRESET_M  = 12,
    parameter int PRESET_S  = 12
) (
    input  logic       clk_50Mhz,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_vld,
    input  logic [3:0] key,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [6:0] hou,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic [2:0] sel,
    output logic       running,
    output logic [3:0] led4,
    output logic       day_pulse
);

    typedef enum logic [2:0] {ST_RUN, ST_HOLD, ST_SET_H, ST_SET_M, ST_SET_S} state_t;

    localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int CW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] DLY_C = CW'(REP_DLY);
    localparam logic [CW-1:0] PER_C = CW'(REP_PER);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [6:0] HMAX = 7'(HOURS_MAX - 1);
    localparam logic [6:0] MSMAX = 7'd59;

    state_t        r_state, w_state_nxt;
    logic [6:0]    r_hou, r_min, r_sec;
    logic [2:0]    r_sel, w_sel_nxt;
    logic [3:0]    r_led, w_led_nxt;
    logic          r_run, r_day;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_rep, w_rep_nxt;
    logic          r_up_q, r_dn_q;
    logic          w_up_only, w_dn_only, w_edge, w_step, w_key_evt, w_edit;

    function automatic logic [6:0] f_inc(input logic [6:0] v, input logic [6:0] mx);
        return (v == mx) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] f_dec(input logic [6:0] v, input logic [6:0] mx);
        return (v == 7'd0) ? mx : v - 7'd1;
    endfunction

    assign w_up_only = btn_up & ~btn_dn;
    assign w_dn_only = btn_dn & ~btn_up;
    // Releasing one of two held buttons re-arms the other as a fresh press.
    assign w_edge    = (w_up_only & ~r_up_q) | (w_dn_only & ~r_dn_q);
    assign w_key_evt = key_vld & ((key == 4'd1) | (key == 4'd2) | (key == 4'd3) |
                                  (key == 4'd6) | (key == 4'd7));
    assign w_edit    = (r_state == ST_SET_H) | (r_state == ST_SET_M) | (r_state == ST_SET_S);

    // Repeat timer: phase 0 waits REP_DLY after the press, phase 1 steps every REP_PER.
    always_comb begin
        w_step    = 1'b0;
        w_cnt_nxt = r_cnt;
        w_rep_nxt = r_rep;
        if (!(w_up_only | w_dn_only)) begin
            w_cnt_nxt = '0;
            w_rep_nxt = 1'b0;
        end else if (w_edge) begin
            w_step    = 1'b1;
            w_cnt_nxt = ONE_C;
            w_rep_nxt = 1'b0;
        end else if ((!r_rep && r_cnt == DLY_C) || (r_rep && r_cnt == PER_C)) begin
            w_step    = 1'b1;
            w_cnt_nxt = ONE_C;
            w_rep_nxt = 1'b1;
        end else if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + ONE_C;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (key_vld) begin
            case (key)
                4'd1:    w_state_nxt = ST_SET_H;
                4'd2:    w_state_nxt = ST_SET_M;
                4'd3:    w_state_nxt = ST_SET_S;
                4'd6:    w_state_nxt = ST_RUN;
                4'd7:    w_state_nxt = ST_HOLD;
                default: w_state_nxt = r_state;
            endcase
        end
        w_sel_nxt = 3'b000;
        w_led_nxt = 4'b1000;
        case (w_state_nxt)
            ST_HOLD:  w_led_nxt = 4'b0101;
            ST_SET_H: begin w_led_nxt = 4'b0001; w_sel_nxt = 3'b100; end
            ST_SET_M: begin w_led_nxt = 4'b0010; w_sel_nxt = 3'b010; end
            ST_SET_S: begin w_led_nxt = 4'b0100; w_sel_nxt = 3'b001; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            r_hou  <= '0;
            r_min  <= '0;
            r_sec  <= '0;
            r_sel  <= 3'b000;
            r_led  <= 4'b1000;
            r_run  <= 1'b1;
            r_day  <= 1'b0;
            r_cnt  <= '0;
            r_rep  <= 1'b0;
            r_up_q <= 1'b0;
            r_dn_q <= 1'b0;
        end else begin
            r_sel  <= w_sel_nxt;
            r_led  <= w_led_nxt;
            r_run  <= (w_state_nxt == ST_RUN);
            r_day  <= 1'b0;
            r_cnt  <= w_cnt_nxt;
            r_rep  <= w_rep_nxt;
            r_up_q <= w_up_only;
            r_dn_q <= w_dn_only;
            if (w_key_evt) begin
                if (key == 4'd7) begin
                    r_hou <= 7'(PRESET_H);
                    r_min <= 7'(PRESET_M);
                    r_sec <= 7'(PRESET_S);
                end
            end else if (w_step && w_edit) begin
                case (r_state)
                    ST_SET_H: r_hou <= btn_up ? f_inc(r_hou, HMAX)  : f_dec(r_hou, HMAX);
                    ST_SET_M: r_min <= btn_up ? f_inc(r_min, MSMAX) : f_dec(r_min, MSMAX);
                    default:  r_sec <= btn_up ? f_inc(r_sec, MSMAX) : f_dec(r_sec, MSMAX);
                endcase
            end else if (tick_1hz && r_state == ST_RUN) begin
                r_sec <= f_inc(r_sec, MSMAX);
                if (r_sec == MSMAX) begin
                    r_min <= f_inc(r_min, MSMAX);
                    if (r_min == MSMAX) begin
                        r_hou <= f_inc(r_hou, HMAX);
                        r_day <= (r_hou == HMAX);
                    end
                end
            end
        end
    end

    assign hou       = r_hou;
    assign min       = r_min;
    assign sec       = r_sec;
    assign sel       = r_sel;
    assign led4      = r_led;
    assign running   = r_run;
    assign day_pulse = r_day;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: one 24 h instance plus a 12 h instance for the wrap case.
module tb_time_set_ctrl;

    logic       clk_50Mhz = 1'b0;
    logic       rst_n = 1'b0, tick_1hz = 1'b0, key_vld = 1'b0, btn_up = 1'b0, btn_dn = 1'b0;
    logic [3:0] key = 4'd0;
    logic [6:0] hou, min, sec, hou12, min12, sec12;
    logic [2:0] sel, sel12;
    logic [3:0] led4, led12;
    logic       running, day_pulse, run12, day12;
    int         checks = 0, errors = 0;
    int         exp_s;

    always #5 clk_50Mhz = ~clk_50Mhz;

    time_set_ctrl #(.HOURS_MAX(24), .REP_DLY(8), .REP_PER(4),
                    .PRESET_H(23), .PRESET_M(59), .PRESET_S(59)) dut (
        .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .tick_1hz(tick_1hz), .key_vld(key_vld),
        .key(key), .btn_up(btn_up), .btn_dn(btn_dn), .hou(hou), .min(min), .sec(sec),
        .sel(sel), .running(running), .led4(led4), .day_pulse(day_pulse));

    time_set_ctrl #(.HOURS_MAX(12), .REP_DLY(8), .REP_PER(4),
                    .PRESET_H(11), .PRESET_M(59), .PRESET_S(59)) dut12 (
        .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .tick_1hz(tick_1hz), .key_vld(key_vld),
        .key(key), .btn_up(btn_up), .btn_dn(btn_dn), .hou(hou12), .min(min12), .sec(sec12),
        .sel(sel12), .running(run12), .led4(led12), .day_pulse(day12));

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k);
        key_vld = 1'b1; key = k;
        cyc();
        key_vld = 1'b0; key = 4'd0;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".h"}, int'(hou), h);
        chk({tag, ".m"}, int'(min), m);
        chk({tag, ".s"}, int'(sec), s);
    endtask

    initial begin
        cyc(); cyc();
        rst_n = 1'b1;
        chk_time("rst", 0, 0, 0);
        chk("rst.sel", int'(sel), 0);
        chk("rst.run", int'(running), 1);
        chk("rst.led", int'(led4), 4'b1000);
        chk("rst.day", int'(day_pulse), 0);

        for (int i = 0; i < 5; i++) begin tick(); cyc(); end
        chk_time("cnt5", 0, 0, 5);
        chk("cnt5.led", int'(led4), 4'b1000);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk_time("midrst", 0, 0, 0);

        press_key(4'd7);
        chk_time("preset", 23, 59, 59);
        chk("preset.led", int'(led4), 4'b0101);
        chk("preset.run", int'(running), 0);
        chk("preset12.h", int'(hou12), 11);
        tick();
        chk("hold.frozen.s", int'(sec), 59);
        press_key(4'd6);
        chk("run.led", int'(led4), 4'b1000);
        tick();
        chk_time("wrap", 0, 0, 0);
        chk("wrap.day", int'(day_pulse), 1);
        chk("wrap12.h", int'(hou12), 0);
        chk("wrap12.day", int'(day12), 1);
        cyc();
        chk("wrap.day_off", int'(day_pulse), 0);
        chk("wrap12.day_off", int'(day12), 0);

        press_key(4'd2);
        chk("setm.sel", int'(sel), 3'b010);
        chk("setm.led", int'(led4), 4'b0010);
        btn_dn = 1'b1; cyc(); btn_dn = 1'b0;
        chk("m.dnwrap", int'(min), 59);
        chk("m.hou_keep", int'(hou), 0);
        cyc();

        press_key(4'd1);
        chk("seth.sel", int'(sel), 3'b100);
        btn_dn = 1'b1; cyc(); btn_dn = 1'b0; cyc();
        chk("h.dnwrap", int'(hou), 23);
        btn_up = 1'b1; cyc(); btn_up = 1'b0; cyc();
        chk("h.upwrap", int'(hou), 0);
        chk("h.min_keep", int'(min), 59);

        press_key(4'd3);
        chk("sets.sel", int'(sel), 3'b001);
        for (int i = 0; i < 10; i++) begin btn_up = 1'b1; cyc(); btn_up = 1'b0; cyc(); end
        chk("s.ten", int'(sec), 10);

        // Held press: steps visible 1, 9, 13 and 17 cycles after assertion.
        btn_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            exp_s = 10 + ((i >= 1) ? 1 : 0) + ((i >= 9) ? 1 : 0)
                       + ((i >= 13) ? 1 : 0) + ((i >= 17) ? 1 : 0);
            chk($sformatf("hold.c%0d", i), int'(sec), exp_s);
        end
        btn_dn = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        chk("both.s", int'(sec), 14);
        btn_dn = 1'b0; cyc();
        chk("reprs.s", int'(sec), 15);
        btn_up = 1'b0; cyc();

        key_vld = 1'b1; key = 4'd6; tick_1hz = 1'b1;
        cyc();
        key_vld = 1'b0; key = 4'd0; tick_1hz = 1'b0;
        chk("k6tick.run", int'(running), 1);
        chk("k6tick.s", int'(sec), 15);
        tick();
        chk("k6next.s", int'(sec), 16);

        press_key(4'd7);
        press_key(4'd9);
        chk_time("k9", 23, 59, 59);
        chk("k9.sel", int'(sel), 0);
        chk("k9.led", int'(led4), 4'b0101);
        btn_up = 1'b1; cyc(); cyc(); btn_up = 1'b0;
        tick();
        chk_time("holdbtn", 23, 59, 59);

        press_key(4'd3);
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk_time("editrst", 0, 0, 0);
        chk("editrst.led", int'(led4), 4'b1000);
        chk("editrst.sel", int'(sel), 0);
        btn_up = 1'b0; cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Registered, parametrised time-of-day controller for the clock display path. Holds the hour/minute/second counters, advances them from a 1 Hz tick when running, and handles field selection, up/down editing with press-and-hold auto-repeat, preset load and run/stop. It sits between the key/button conditioning stage and the 7-segment display driver. Every output is a flop; nothing is combinationally derived from inputs.

## Interface
Parameters:
- HOURS_MAX, 24: hour modulus; legal range 2..100.
- REP_DLY, 25_000_000: hold cycles before the first auto-repeat step.
- REP_PER, 5_000_000: cycles between subsequent auto-repeat steps.
- PRESET_H / PRESET_M / PRESET_S, 12 / 12 / 12: values loaded by key 7. Each must be below its field modulus.

Ports:
- clk_50Mhz  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- tick_1hz  in  1  one-cycle pulse, once per second.
- key_vld  in  1  one-cycle strobe qualifying key.
- key  in  4  key code, sampled only when key_vld=1.
- btn_up / btn_dn  in  1 each  debounced level, 1 = held.
- hou / min / sec  out  7 each  binary time fields.
- sel  out  3  one-hot edit select {h,m,s}; 000 when not editing.
- running  out  1  1 in RUN state.
- led4  out  4  mode indicator.
- day_pulse  out  1  one-cycle pulse on hour wrap while counting.

## Operation
- States: RUN, HOLD, SET_H, SET_M, SET_S.
- Reset (rst_n=0 at a clock edge) sets: state=RUN, hou=min=sec=0, sel=000, running=1, led4=1000, day_pulse=0, repeat counter cleared. This applies mid-edit and mid-repeat.
- Key decode (key_vld=1):
  - 1 -> SET_H.
  - 2 -> SET_M.
  - 3 -> SET_S.
  - 6 -> RUN.
  - 7 -> load PRESET_*, then HOLD.
  - Any other code: no effect.
- Key transitions are legal from any state.
- led4 per state: RUN 1000, HOLD 0101, SET_H 0001, SET_M 0010, SET_S 0100.
- sel per state: SET_H 100, SET_M 010, SET_S 001, otherwise 000.
- Counting happens only in RUN, on tick_1hz:
  - sec increments; sec 59->0 carries into min.
  - min 59->0 carries into hou.
  - hou HOURS_MAX-1 -> 0 raises day_pulse for one cycle.
- In HOLD and all SET states, tick_1hz is ignored and the time is frozen.
- Editing happens only in SET states and acts on the selected field only. Edits never carry into a neighbour field.
  - Up: value+1; wraps max->0.
  - Down: value-1; wraps 0->max.
  - max is 59 for min/sec and HOURS_MAX-1 for hou.
- Step generation, evaluated on the level of exactly one button held (btn_up xor btn_dn):
  - Rising edge of that button: one step.
  - Held REP_DLY cycles after the edge: one step.
  - Then one step every REP_PER cycles while still held.
- Both buttons held, or neither held: no step, and the repeat counter is cleared. Releasing one button while the other stays held counts as a fresh press of the remaining button.
- Buttons in RUN or HOLD: no step. The repeat counter still tracks, so entering a SET state mid-hold produces no spurious edge step.
- Same-cycle priority: reset > key_vld > button step > tick. A key event in a cycle drops any step or tick due in that same cycle.
- Arithmetic: fields are 7-bit unsigned. Wrap comparisons are done before the add/subtract, so no out-of-range value is ever visible.

## Timing
- Key strobe at edge n -> state, sel, led4 and running updated at edge n+1. A preset load is visible at n+1.
- Button rising edge seen at edge n -> field updated at n+1.
- Continuous hold from edge n -> repeat steps at n+REP_DLY+1, then every REP_PER cycles after that.
- tick at edge n in RUN -> sec updated at n+1. A full carry chain (e.g. 23:59:59 -> 00:00:00) completes in that same cycle, with day_pulse high for cycle n+1 only.
- The repeat counter width is sized for REP_DLY and REP_PER and saturates rather than wraps.

## Test plan
(Simulation parameters: REP_DLY=8, REP_PER=4.)
- Reset, then 5 ticks -> 00:00:05, running=1, led4=1000. Assert rst_n=0 for one edge mid-count -> 00:00:00 on the next cycle.
- Load 23:59:59 via key 7 with PRESET=23/59/59, key 6, then one tick -> 00:00:00 with day_pulse=1 for exactly one cycle. Second case: HOURS_MAX=12 and preset 11:59:59 wraps to 0.
- Key 2, btn_dn pressed once at min=0 -> min=59 and hou unchanged. Key 1, btn_up at hou=23 -> hou=0.
- Key 3, btn_up held 20 cycles from sec=10 -> steps at +1, +9, +13, +17 cycles; sec=14, final value 14. Both buttons held -> value constant.
- Key 6 strobe and tick_1hz in the same cycle while in SET_S -> state RUN, sec unchanged that cycle; the next tick increments sec.
- Key code 9, and btn_up while in HOLD -> no change to time, sel=000, led4=0101.
